mmio_bridge: RTL and testbench
==============================

MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, using the port names clk and rst_n.
REQ-002 The module SHALL have the following parameters (name, default, meaning):
- DATA_W, 16, CPU data width.
- RDATA_W, 10, peripheral read-data width; must be 1..DATA_W.
- NUM_CH, 4, peripheral channel count; must be 1..7.
- TIMEOUT, 15, maximum WAIT cycles before abort; must be at least 1.
REQ-003 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- addr, in, 16, CPU EX/DM address.
- wdata, in, DATA_W, CPU store data.
- re, in, 1, CPU load request.
- we, in, 1, CPU store request.
- err_clr, in, 1, clears the sticky error.
- stall, out, 1, freezes the CPU pipeline.
- io_rdata, out, DATA_W, load result.
- io_err, out, 1, sticky error flag.
- err_ch, out, 3, index of the last channel that faulted.
- per_sel, out, NUM_CH, one-hot channel select.
- per_re, out, 1, peripheral read strobe.
- per_we, out, 1, peripheral write strobe.
- per_addr, out, 13, address offset addr[12:0].
- per_wdata, out, DATA_W, peripheral write data.
- per_rdy, in, NUM_CH, per-channel completion.
- per_rdata, in, NUM_CH*RDATA_W, flattened read data; channel k occupies bits [k*RDATA_W +: RDATA_W].

Function
REQ-004 An access SHALL be an I/O hit when (re|we) is 1 and addr[15:13] is not 0; channel index = addr[15:13]-1.
REQ-005 A hit with channel index >= NUM_CH SHALL be unmapped:
- no stall;
- io_rdata = 0 in the same cycle;
- io_err set and err_ch = addr[15:13]-1 at the next edge.
REQ-006 When re and we are both 1, the access SHALL be treated as a write.
REQ-007 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-008 IDLE -> REQ on a mapped hit; on that edge the module latches channel, addr[12:0], wdata and direction.
REQ-009 stall SHALL equal (state==IDLE and mapped hit) OR state==REQ OR state==WAIT, computed combinationally.
REQ-010 In REQ, exactly one per_sel bit and exactly one of per_re/per_we SHALL be 1, for one cycle only.
REQ-011 per_addr and per_wdata SHALL hold the latched values throughout REQ and WAIT.
REQ-012 In REQ and WAIT, the module SHALL sample per_rdy[ch] each cycle.
- If it is 1, go to DONE; for a read, capture per_rdata of channel ch zero-extended to DATA_W into io_rdata.
- REQ also exits to WAIT when per_rdy[ch] is 0.
REQ-013 In WAIT, a cycle counter SHALL increment each cycle.
- When the counter reaches TIMEOUT without ready: go to DONE, io_rdata = all ones, set io_err, err_ch = ch.
- The counter SHALL clear on entry to REQ.
REQ-014 In DONE, stall SHALL be 0 for exactly one cycle and io_rdata SHALL be valid; the CPU request present in DONE is the completed access and SHALL NOT restart the FSM. Next state is IDLE.
REQ-015 Minimum mapped latency SHALL be 2 stall cycles (IDLE-hit, REQ with ready); maximum SHALL be TIMEOUT+2.
REQ-016 io_rdata SHALL hold its value outside DONE until the next capture.
REQ-017 A non-hit access (addr[15:13]==0) SHALL never stall and SHALL never assert any per_* strobe.
REQ-018 io_err SHALL be sticky until err_clr; if set and clear occur in the same cycle, set wins.
REQ-019 per_rdy on a non-selected channel SHALL be ignored.

Reset
REQ-020 While rst_n=0, the following SHALL be forced asynchronously:
- state = IDLE, counter = 0;
- stall = 0;
- per_sel = 0, per_re = 0, per_we = 0;
- per_addr = 0, per_wdata = 0, io_rdata = 0;
- io_err = 0, err_ch = 0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no strobe glitch; after release the module SHALL be in IDLE.

Verification
REQ-022 Read ch0: addr=0x2005, re=1, per_rdy[0]=1 in REQ, per_rdata[9:0]=0x3FF -> stall high for 2 cycles, per_sel=0001, per_addr=0x0005, io_rdata=0x03FF in DONE.
REQ-023 Write ch2: addr=0x6010, we=1, wdata=0xBEEF, per_rdy[2] raised 3 cycles after REQ -> per_we one cycle, per_wdata=0xBEEF, stall high 5 cycles, no error.
REQ-024 Timeout: read ch1 with per_rdy held at 0 and TIMEOUT=15 -> DONE after 17 stall cycles, io_rdata=0xFFFF, io_err=1, err_ch=1; err_clr pulse -> io_err=0.
REQ-025 Unmapped: NUM_CH=4, addr=0xC000, re=1 -> stall=0, io_rdata=0, no strobes, io_err=1, err_ch=5.
REQ-026 rst_n deasserted during WAIT -> all outputs return to reset values immediately; a subsequent read of ch0 completes normally.
REQ-027 re=we=1 on ch3, and separately addr=0x1234 with re=1 -> the first produces a per_we strobe only; the second produces no stall and no strobes.

Source files
------------

// File: rtl/mmio_bridge.sv
// CPU-to-peripheral MMIO bridge. It decodes addr[15:13] into a channel and runs one
// strobe/handshake per access, stalling the CPU and aborting on a WAIT timeout.
//
// state | meaning
// IDLE  | no access in flight, decode CPU request
// REQ   | one-cycle select + read/write strobe to latched channel
// WAIT  | strobe released, polling per_rdy[ch] with timeout counter
// DONE  | access complete, stall released for one cycle
module mmio_bridge #(
  parameter int DATA_W  = 16,
  parameter int RDATA_W = 10,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 addr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        re,
  input  logic                        we,
  input  logic                        err_clr,
  output logic                        stall,
  output logic [DATA_W-1:0]           io_rdata,
  output logic                        io_err,
  output logic [2:0]                  err_ch,
  output logic [NUM_CH-1:0]           per_sel,
  output logic                        per_re,
  output logic                        per_we,
  output logic [12:0]                 per_addr,
  output logic [DATA_W-1:0]           per_wdata,
  input  logic [NUM_CH-1:0]           per_rdy,
  input  logic [NUM_CH*RDATA_W-1:0]   per_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [2:0]          ch_q;
  logic                dir_we;
  logic [DATA_W-1:0]   rdata_q;

  logic                hit;
  logic                mapped_hit;
  logic                unmapped_hit;
  logic [2:0]          hit_ch;
  logic                rdy_sel;
  logic [RDATA_W-1:0]  rdata_sel;

  assign hit          = (re | we) && (addr[15:13] != 3'd0);
  assign hit_ch       = addr[15:13] - 3'd1;
  assign mapped_hit   = hit && (int'(hit_ch) < NUM_CH);
  assign unmapped_hit = (state == IDLE) && hit && !mapped_hit;

  // Stall must be low during reset even if the CPU presents a mapped request.
  assign stall = rst_n && (((state == IDLE) && mapped_hit) || (state == REQ) || (state == WAIT));

  // Unmapped loads complete in their own cycle with zero data; the held value is untouched.
  assign io_rdata = unmapped_hit ? '0 : rdata_q;

  always_comb begin
    rdy_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ch_q) == k) begin
        rdy_sel   = per_rdy[k];
        rdata_sel = per_rdata[k*RDATA_W +: RDATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ch_q      <= 3'd0;
      dir_we    <= 1'b0;
      rdata_q   <= '0;
      io_err    <= 1'b0;
      err_ch    <= 3'd0;
      per_sel   <= '0;
      per_re    <= 1'b0;
      per_we    <= 1'b0;
      per_addr  <= 13'd0;
      per_wdata <= '0;
    end else begin
      per_sel <= '0;
      per_re  <= 1'b0;
      per_we  <= 1'b0;

      // Clear first so any error set below in the same cycle takes priority.
      if (err_clr) io_err <= 1'b0;

      case (state)
        IDLE: begin
          if (unmapped_hit) begin
            io_err <= 1'b1;
            err_ch <= hit_ch;
          end else if (mapped_hit) begin
            state     <= REQ;
            ch_q      <= hit_ch;
            dir_we    <= we;
            per_addr  <= addr[12:0];
            per_wdata <= wdata;
            wait_cnt  <= '0;
            per_re    <= !we;
            per_we    <= we;
            for (int k = 0; k < NUM_CH; k++) begin
              per_sel[k] <= (int'(hit_ch) == k);
            end
          end
        end
        REQ: begin
          if (rdy_sel) begin
            state <= DONE;
            if (!dir_we) rdata_q <= DATA_W'(rdata_sel);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (rdy_sel) begin
            state <= DONE;
            if (!dir_we) rdata_q <= DATA_W'(rdata_sel);
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            rdata_q <= '1;
            io_err  <= 1'b1;
            err_ch  <= ch_q;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed cases then random accesses scored against an
// access-level model (stall length, strobe counts, load data, sticky error).
module tb_mmio_bridge;

  localparam int DATA_W  = 16;
  localparam int RDATA_W = 10;
  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [15:0]               addr = '0;
  logic [DATA_W-1:0]         wdata = '0;
  logic                      re = 1'b0;
  logic                      we = 1'b0;
  logic                      err_clr = 1'b0;
  logic                      stall;
  logic [DATA_W-1:0]         io_rdata;
  logic                      io_err;
  logic [2:0]                err_ch;
  logic [NUM_CH-1:0]         per_sel;
  logic                      per_re;
  logic                      per_we;
  logic [12:0]               per_addr;
  logic [DATA_W-1:0]         per_wdata;
  logic [NUM_CH-1:0]         per_rdy = '0;
  logic [NUM_CH*RDATA_W-1:0] per_rdata = '0;

  mmio_bridge #(
    .DATA_W(DATA_W), .RDATA_W(RDATA_W), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .re(re), .we(we),
    .err_clr(err_clr), .stall(stall), .io_rdata(io_rdata), .io_err(io_err),
    .err_ch(err_ch), .per_sel(per_sel), .per_re(per_re), .per_we(per_we),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_rdy(per_rdy),
    .per_rdata(per_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic              exp_err    = 1'b0;
  logic [2:0]        exp_err_ch = 3'd0;
  logic [DATA_W-1:0] exp_rdata  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stall"}, 32'(stall), 0);
    check_val({tag, "_strobes"}, {per_sel, per_re, per_we}, 0);
    check_val({tag, "_per_addr"}, 32'(per_addr), 0);
    check_val({tag, "_per_wdata"}, 32'(per_wdata), 0);
    check_val({tag, "_io_rdata"}, 32'(io_rdata), 0);
    check_val({tag, "_err"}, {io_err, err_ch}, 0);
  endtask

  // Runs one CPU access starting just after a rising edge. d = cycles after REQ
  // at which the selected channel raises ready; d > TIMEOUT means it never does.
  task automatic do_access(input logic [15:0] a, input logic r, input logic w,
                           input logic [DATA_W-1:0] wd, input int d,
                           input logic [RDATA_W-1:0] rd, input logic clr);
    int idx, ch, exp_stall, cyc, stall_n, re_n, we_n;
    bit hit, mapped, tmo, hold_bad, sel_bad, done, clr_used;
    logic [NUM_CH-1:0] exp_sel;
    logic [DATA_W-1:0] exp_done;

    idx       = int'(a[15:13]);
    hit       = (r || w) && idx != 0;
    ch        = idx - 1;
    mapped    = hit && ch < NUM_CH;
    tmo       = mapped && d > TIMEOUT;
    exp_stall = mapped ? (((d < TIMEOUT) ? d : TIMEOUT) + 2) : 0;
    exp_sel   = mapped ? NUM_CH'(1 << ch) : '0;
    clr_used  = clr && !mapped;

    if (!mapped)   exp_done = hit ? '0 : exp_rdata;
    else if (tmo)  exp_done = '1;
    else if (!w)   exp_done = DATA_W'(rd);
    else           exp_done = exp_rdata;

    addr = a; re = r; we = w; wdata = wd; err_clr = clr_used;
    cyc = 0; stall_n = 0; re_n = 0; we_n = 0;
    hold_bad = 0; sel_bad = 0; done = 0;

    while (!done && cyc < 40) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (mapped && k == ch) begin
          per_rdy[k] = (cyc >= 1) && (cyc - 1 >= d);
          per_rdata[k*RDATA_W +: RDATA_W] = rd;
        end else begin
          per_rdy[k] = 1'($urandom_range(0, 1));
          per_rdata[k*RDATA_W +: RDATA_W] = RDATA_W'($urandom);
        end
      end
      @(negedge clk);
      if (stall)  stall_n++;
      if (per_re) re_n++;
      if (per_we) we_n++;
      if (per_re || per_we) begin
        if (per_sel != exp_sel || cyc != 1) sel_bad = 1;
      end else if (per_sel != '0) begin
        sel_bad = 1;
      end
      if (mapped && cyc >= 1 && stall && (per_addr != a[12:0] || per_wdata != wd)) hold_bad = 1;
      if (!stall) begin
        check_val("rdata_done", 32'(io_rdata), 32'(exp_done));
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check_val("stall_bound", 32'(cyc), 32'(exp_stall + 1));

    check_val("stall_cycles", 32'(stall_n), 32'(exp_stall));
    check_val("re_strobes", 32'(re_n), 32'(mapped && !w));
    check_val("we_strobes", 32'(we_n), 32'(mapped && w));
    check_val("sel_onehot", 32'(sel_bad), 0);
    check_val("addr_hold", 32'(hold_bad), 0);

    re = 1'b0; we = 1'b0; err_clr = 1'b0; per_rdy = '0;
    addr = 16'($urandom);
    if (hit && !mapped) begin
      exp_err = 1'b1; exp_err_ch = 3'(idx - 1);
    end else if (tmo) begin
      exp_err = 1'b1; exp_err_ch = 3'(ch);
    end else if (clr_used) begin
      exp_err = 1'b0;
    end
    if (mapped) exp_rdata = exp_done;

    @(negedge clk);
    check_val("io_err", 32'(io_err), 32'(exp_err));
    check_val("err_ch", 32'(err_ch), 32'(exp_err_ch));
    check_val("rdata_hold", 32'(io_rdata), 32'(exp_rdata));
    check_val("idle_quiet", {stall, per_sel, per_re, per_we}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int kind, d;
    logic [15:0] a;
    logic r, w;

    // Mapped request held during reset must not stall or strobe.
    addr = 16'h2005; re = 1'b1; wdata = 16'h5A5A;
    #12;
    check_reset_outputs("in_reset");
    re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(16'h2005, 1'b1, 1'b0, 16'h1111, 0, 10'h3FF, 1'b0);
    do_access(16'h6010, 1'b0, 1'b1, 16'hBEEF, 3, 10'h000, 1'b0);
    do_access(16'h4000, 1'b1, 1'b0, 16'h0000, 100, 10'h155, 1'b0);
    do_access(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 10'h000, 1'b1);
    do_access(16'hC000, 1'b1, 1'b0, 16'h0000, 0, 10'h000, 1'b0);
    do_access(16'hE000, 1'b1, 1'b0, 16'h0000, 0, 10'h000, 1'b1);
    do_access(16'h8000, 1'b1, 1'b1, 16'hCAFE, 1, 10'h2AA, 1'b0);
    do_access(16'h1234, 1'b1, 1'b0, 16'h0000, 0, 10'h000, 1'b0);
    do_access(16'h2100, 1'b1, 1'b0, 16'h0000, TIMEOUT, 10'h0A5, 1'b0);
    do_access(16'h2100, 1'b1, 1'b0, 16'h0000, TIMEOUT + 1, 10'h0A5, 1'b0);

    // Reset in the middle of WAIT with nonzero latched state.
    addr = 16'h4ABC; re = 1'b1; wdata = 16'h1234; per_rdy = '0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_wait_reset");
    re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_err = 1'b0; exp_err_ch = 3'd0; exp_rdata = '0;
    @(posedge clk); #1;
    do_access(16'h2007, 1'b1, 1'b0, 16'h0000, 2, 10'h1C3, 1'b0);

    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind < 7)      d = int'($urandom_range(0, 5));
      else if (kind < 9) d = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
      else               d = int'($urandom_range(6, TIMEOUT));
      do_access(a, r, w, 16'($urandom), d, RDATA_W'($urandom),
                1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
